// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes, guards memory waits with a timeout and counts retirements.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR on mem_ready
// DECODE | classify opcode, select immediate format
// EXEC   | ALU operation, PC update, branch resolution
// MEM    | data access at ALU address (LDUR/STUR)
// WB     | register file write
// HALT   | illegal opcode or memory timeout; held until reset
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic [10:0]       opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [2:0]        state,
  output logic              mem_req,
  output logic              mem_we,
  output logic              iord,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_src,
  output logic              reg2loc,
  output logic              alusrc,
  output logic              mem2reg,
  output logic              regwrite,
  output logic [3:0]        aluctrl,
  output logic [2:0]        signop,
  output logic              illegal,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_LDUR, C_STUR, C_ADD, C_SUB, C_AND, C_ORR, C_CBZ, C_B, C_MOVZ, C_ILL
  } cls_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [2:0] SG_I  = 3'b000;
  localparam logic [2:0] SG_D  = 3'b001;
  localparam logic [2:0] SG_B  = 3'b010;
  localparam logic [2:0] SG_CB = 3'b011;
  localparam logic [2:0] SG_IW = 3'b100;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            cur, nxt;
  cls_t              cls;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              set_illegal, set_fault, retire;
  logic              r2l_dec, src_exec, alu_held;
  logic [2:0]        sig_dec;
  logic [3:0]        alu_exec;

  always_comb begin
    cls = C_ILL;
    casez (opcode)
      11'b11111000010: cls = C_LDUR;
      11'b11111000000: cls = C_STUR;
      11'b10001011000: cls = C_ADD;
      11'b11001011000: cls = C_SUB;
      11'b10001010000: cls = C_AND;
      11'b10101010000: cls = C_ORR;
      11'b10110100???: cls = C_CBZ;
      11'b000101?????: cls = C_B;
      11'b110100101??: cls = C_MOVZ;
      default:         cls = C_ILL;
    endcase
  end

  // Per-class controls shared by DECODE, EXEC and WB.
  always_comb begin
    r2l_dec  = (cls == C_STUR) || (cls == C_CBZ);
    src_exec = (cls == C_LDUR) || (cls == C_STUR) || (cls == C_MOVZ);
    alu_held = (cls == C_ADD) || (cls == C_SUB) || (cls == C_AND) ||
               (cls == C_ORR) || (cls == C_MOVZ);
    case (cls)
      C_LDUR, C_STUR: sig_dec = SG_D;
      C_B:            sig_dec = SG_B;
      C_CBZ:          sig_dec = SG_CB;
      C_MOVZ:         sig_dec = SG_IW;
      default:        sig_dec = SG_I;
    endcase
    case (cls)
      C_LDUR, C_STUR, C_ADD: alu_exec = ALU_ADD;
      C_SUB:                 alu_exec = ALU_SUB;
      C_ORR:                 alu_exec = ALU_ORR;
      C_CBZ, C_MOVZ:         alu_exec = ALU_PASSB;
      default:               alu_exec = ALU_AND;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (resetl) begin
      cur      <= ST_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      fault    <= 1'b0;
      retired  <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      if (set_illegal) illegal <= 1'b1;
      if (set_fault)   fault   <= 1'b1;
      if (retire)      retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    nxt         = cur;
    wait_nxt    = '0;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg2loc     = 1'b0;
    alusrc      = 1'b0;
    mem2reg     = 1'b0;
    regwrite    = 1'b0;
    aluctrl     = ALU_AND;
    signop      = SG_I;
    case (cur)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          nxt      = ST_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_fault = 1'b1;
          nxt       = ST_HALT;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ST_DECODE: begin
        reg2loc = r2l_dec;
        signop  = sig_dec;
        if (cls == C_ILL) begin
          set_illegal = 1'b1;
          nxt         = ST_HALT;
        end else begin
          nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        aluctrl  = alu_exec;
        alusrc   = src_exec;
        reg2loc  = r2l_dec;
        signop   = sig_dec;
        pc_write = 1'b1;
        pc_src   = (cls == C_B) || ((cls == C_CBZ) && zero);
        case (cls)
          C_LDUR, C_STUR: nxt = ST_MEM;
          C_B, C_CBZ: begin
            nxt    = ST_FETCH;
            retire = 1'b1;
          end
          default: nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls == C_STUR);
        aluctrl = ALU_ADD;
        alusrc  = 1'b1;
        signop  = SG_D;
        reg2loc = (cls == C_STUR);
        if (mem_ready) begin
          if (cls == C_STUR) begin
            nxt    = ST_FETCH;
            retire = 1'b1;
          end else begin
            nxt = ST_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          set_fault = 1'b1;
          nxt       = ST_HALT;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ST_WB: begin
        regwrite = 1'b1;
        mem2reg  = (cls == C_LDUR);
        if (alu_held) begin
          aluctrl = alu_exec;
          alusrc  = src_exec;
        end
        nxt    = ST_FETCH;
        retire = 1'b1;
      end
      ST_HALT: nxt = ST_HALT;
      default: nxt = ST_FETCH;
    endcase
  end

  assign state = cur;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the LEGv8 datapath: PC register, instruction register, register file, sign extender, ALU, and a single shared instruction/data memory with a ready handshake.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives all datapath enables, mux selects and the ALU/sign-extend controls.
- Waits on the memory handshake, detects illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting for mem_ready in one access before fault.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- resetl  in  1  reset, synchronous, active-high.
- opcode  in  11  instruction[31:21] from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- iord  out  1  memory address select: 0=PC, 1=ALU result.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0=PC+4, 1=PC+extimm.
- reg2loc  out  1  RB select: 1=instruction[4:0].
- alusrc  out  1  ALU B input select: 1=extimm.
- mem2reg  out  1  writeback select: 1=memory data.
- regwrite  out  1  register file write enable.
- aluctrl  out  4  AND=0000, ORR=0001, ADD=0010, SUB=0110, PASSB=0111.
- signop  out  3  immediate format: I=000, D=001, B=010, CB=011, IW=100.
- illegal  out  1  sticky; undecodable opcode reached DECODE.
- fault  out  1  sticky; memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: state=FETCH, illegal=0, fault=0, retired=0, wait counter=0. Reset is honoured in any state, including mid-wait and HALT; it takes effect at the next edge.
- Decode classes (x = don't care):
  - LDUR 11111000010
  - STUR 11111000000
  - ADD 10001011000
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
  - CBZ 10110100xxx
  - B 000101xxxxx
  - MOVZ 110100101xx
  - Anything else is illegal.
- Outputs are combinational from the registered state plus opcode. Every output not listed for a state is 0.
- FETCH:
  - mem_req=1, iord=0.
  - On mem_ready: ir_write=1, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE:
  - reg2loc=1 for STUR/CBZ.
  - signop per class.
  - Illegal opcode: set illegal, go to HALT. Otherwise go to EXEC.
- EXEC:
  - aluctrl: ADD for LDUR/STUR/ADD; SUB for SUB; AND; ORR; PASSB for CBZ/MOVZ.
  - alusrc=1 for LDUR/STUR/MOVZ. reg2loc and signop held as in DECODE.
  - pc_write=1.
  - pc_src=1 for B, or for CBZ with zero=1; otherwise 0.
  - Next state: LDUR/STUR go to MEM; R-type and MOVZ go to WB; B/CBZ go to FETCH and retire.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for STUR.
  - aluctrl=ADD, alusrc=1, signop=D, reg2loc=1 for STUR.
  - On mem_ready: LDUR goes to WB; STUR goes to FETCH and retires.
- WB:
  - regwrite=1. mem2reg=1 for LDUR.
  - R-type/MOVZ controls (aluctrl, alusrc) held as in EXEC.
  - Go to FETCH and retire.
- Retire: retired increments by 1 on the edge leaving the final state of an instruction. Wraps modulo 2^CNT_W.
- Wait counter:
  - Cleared on entry to FETCH/MEM and whenever mem_ready=1.
  - If it reaches MEM_TIMEOUT-1 with mem_ready=0, the next edge sets fault and goes to HALT. mem_ready in the same cycle wins over timeout.
- HALT: all strobes 0. Stays until reset. illegal/fault hold.
- mem_ready outside FETCH/MEM is ignored.
- At most one of ir_write, regwrite, mem_we is high in any cycle.

Test Plan:
- Reset then ADD (opcode 10001011000), mem_ready=1 every cycle -> state sequence 0,1,2,4,0; regwrite=1 only in WB; retired=1 after 4 cycles.
- LDUR with mem_ready asserted on the 3rd MEM cycle -> MEM held 3 cycles with iord=1, mem_we=0; WB has mem2reg=1; total 7 cycles; retired=1.
- CBZ with zero=1, then CBZ with zero=0 -> EXEC pc_write=1, pc_src=1 then 0; neither visits WB; retired=2.
- Opcode 00000000000 -> DECODE to HALT, illegal=1, all strobes 0 for 10 cycles; resetl=1 -> FETCH, illegal=0.
- MEM_TIMEOUT=16, STUR, mem_ready never asserted in MEM -> HALT exactly 16 cycles after MEM entry, fault=1, mem_we seen only in MEM. Repeat with mem_ready on the 16th cycle -> no fault, FETCH.
- CNT_W=4, 16 back-to-back B instructions -> retired wraps 15 to 0; reset asserted mid-FETCH wait -> FETCH next edge, retired=0.
